// File: rtl/ysyx_ifu_axi_fetch_if.sv
// ysyx_ifu_axi_fetch_if: IFU request/response and AXI4 read-channel bundle.
// master = fetch unit side, slave = IFU core + AXI slave environment side.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

interface ysyx_ifu_axi_fetch_if #(
  parameter int XLEN = `YSYX_XLEN
);
  // IFU request
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            flush;
  // IFU response
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_inst;
  logic            rsp_err;
  // AXI AR
  logic            arvalid;
  logic            arready;
  logic [3:0]      arid;
  logic [XLEN-1:0] araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  // AXI R
  logic            rvalid;
  logic            rready;
  logic [3:0]      rid;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;
  logic            rlast;

  modport master (
    input  req_valid, req_addr, flush,
    input  rsp_ready,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output req_ready,
    output rsp_valid, rsp_inst, rsp_err,
    output arvalid, arid, araddr,
    output arlen, arsize, arburst,
    output rready
  );

  modport slave (
    output req_valid, req_addr, flush,
    output rsp_ready,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  req_ready,
    input  rsp_valid, rsp_inst, rsp_err,
    input  arvalid, arid, araddr,
    input  arlen, arsize, arburst,
    input  rready
  );
endinterface

// File: rtl/ysyx_ifu_axi_fetch.sv
// ysyx_ifu_axi_fetch: single-word IFU fetch over single-beat AXI4 reads.
// Ports: clock, reset (async, active-low), bus (master modport).
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_ifu_axi_fetch #(
  parameter int         XLEN   = `YSYX_XLEN,
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic                  clock,
  input  logic                  reset,
  ysyx_ifu_axi_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_kill;
  logic            w_kill_nxt;
  logic [XLEN-1:0] r_araddr;
  logic [XLEN-1:0] w_araddr_nxt;
  logic [31:0]     r_inst;
  logic [31:0]     w_inst_nxt;
  logic            r_err;
  logic            w_err_nxt;

  logic w_acc;
  logic w_mis;
  logic w_rerr;
  logic w_unused;

  assign w_acc  = bus.req_valid && bus.req_ready;
  assign w_mis  = bus.req_addr[1:0] != 2'b00;
  assign w_rerr = (bus.rresp != 2'b00)
               || (bus.rid != AXI_ID);

  // Single beat: rlast carries no information.
  assign w_unused = bus.rlast ^ (^bus.rdata);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_kill   <= 1'b0;
      r_araddr <= '0;
      r_inst   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_kill   <= w_kill_nxt;
      r_araddr <= w_araddr_nxt;
      r_inst   <= w_inst_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_kill_nxt   = r_kill;
    w_araddr_nxt = r_araddr;
    w_inst_nxt   = r_inst;
    w_err_nxt    = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_mis) begin
            w_inst_nxt  = '0;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_araddr_nxt = {bus.req_addr[XLEN-1:2], 2'b00};
            w_state_nxt  = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        // AR is never retracted; a flush only
        // marks the beat to be thrown away.
        if (bus.flush) w_kill_nxt = 1'b1;
        if (bus.arready) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bus.rvalid) begin
          if (r_kill || bus.flush) begin
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_inst_nxt  = bus.rdata[31:0];
            w_err_nxt   = w_rerr;
            w_state_nxt = S_RESP;
          end
        end else if (bus.flush) begin
          w_kill_nxt = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready || bus.flush) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // req_ready is held low while reset is asserted.
  assign bus.req_ready = (r_state == S_IDLE)
                      && !bus.flush && reset;
  assign bus.arvalid   = (r_state == S_ADDR);
  assign bus.rready    = (r_state == S_DATA);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_inst  = r_inst;
  assign bus.rsp_err   = r_err;
  assign bus.araddr    = r_araddr;
  assign bus.arid      = AXI_ID;
  assign bus.arlen     = 8'h00;
  assign bus.arsize    = 3'b010;
  assign bus.arburst   = 2'b01;

endmodule
